// File: rtl/similarity_pkg.sv
// Shared definitions for the frame similarity feed controller and checker.
package similarity_pkg;

  localparam int unsigned DATA_W        = 1024;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned SIM_THRESHOLD = 4080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_WAIT_CHK,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/bram_pair_align.sv
// Tracks outstanding BRAM reads and captures the aligned A/B word pair
// when the read data for an issued address arrives.
module bram_pair_align #(
  parameter int unsigned DATA_W   = similarity_pkg::DATA_W,
  parameter int unsigned BRAM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b,
  output logic [DATA_W-1:0] xt,
  output logic [DATA_W-1:0] xt_1,
  output logic              beat_valid,
  output logic              pending
);

  logic [BRAM_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]   xt_q, xt_d, xt_1_q, xt_1_d;
  logic                bv_q, bv_d;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int unsigned i = 1; i < BRAM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    xt_d   = xt_q;
    xt_1_d = xt_1_q;
    bv_d   = vld_q[BRAM_LAT-1];
    if (vld_q[BRAM_LAT-1]) begin
      xt_d   = dout_a;
      xt_1_d = dout_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= '0;
      xt_q   <= '0;
      xt_1_q <= '0;
      bv_q   <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      xt_q   <= xt_d;
      xt_1_q <= xt_1_d;
      bv_q   <= bv_d;
    end
  end

  assign xt         = xt_q;
  assign xt_1       = xt_1_q;
  assign beat_valid = bv_q;
  assign pending    = |vld_q;

endmodule

// File: rtl/similarity_feed_ctrl.sv
// Feeds two BRAM frames beat by beat to the similarity checker, waits for
// its verdict (or a timeout) and reports it back with a one-cycle done pulse.
module similarity_feed_ctrl #(
  parameter int unsigned DATA_W   = similarity_pkg::DATA_W,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned BRAM_LAT = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_a,
  input  logic [ADDR_W-1:0]                base_b,
  input  logic [similarity_pkg::CNT_W-1:0] beats,
  output logic                             bram_a_en,
  output logic                             bram_b_en,
  output logic [ADDR_W-1:0]                bram_a_addr,
  output logic [ADDR_W-1:0]                bram_b_addr,
  input  logic [DATA_W-1:0]                bram_a_dout,
  input  logic [DATA_W-1:0]                bram_b_dout,
  output logic [DATA_W-1:0]                xt,
  output logic [DATA_W-1:0]                xt_1,
  output logic                             beat_valid,
  output logic [similarity_pkg::CNT_W-1:0] count,
  output logic                             chk_idle,
  input  logic                             chk_done,
  input  logic                             chk_flag,
  output logic                             busy,
  output logic                             done,
  output logic                             similar,
  output logic                             err
);

  import similarity_pkg::*;

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [CNT_W-1:0]  left_q, left_d, count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, busy_d, idle_q, idle_d, done_q, done_d;
  logic              sim_q, sim_d, err_q, err_d;
  logic              align_pending;

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    left_d   = left_q;
    count_d  = count_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    idle_d   = idle_q;
    done_d   = 1'b0;
    sim_d    = sim_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (beats != '0) begin
            state_d  = ST_ISSUE;
            en_d     = 1'b1;
            addr_a_d = base_a;
            addr_b_d = base_b;
            left_d   = beats - CNT_W'(1);
            count_d  = beats;
            busy_d   = 1'b1;
            idle_d   = 1'b0;
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            sim_d   = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        // left_q counts issues still owed after the one on the bus now
        if (left_q != '0) begin
          left_d   = left_q - CNT_W'(1);
          addr_a_d = addr_a_q + ADDR_W'(1);
          addr_b_d = addr_b_q + ADDR_W'(1);
        end else begin
          en_d    = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!align_pending) begin
          state_d = ST_WAIT_CHK;
          wait_d  = '0;
        end
      end
      ST_WAIT_CHK: begin
        wait_d = wait_q + WAIT_W'(1);
        if (chk_done || (wait_q == WAIT_W'(TIMEOUT - 1))) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idle_d  = 1'b1;
          sim_d   = chk_done & chk_flag;
          err_d   = ~chk_done;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      left_q   <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      sim_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      left_q   <= left_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
      idle_q   <= idle_d;
      done_q   <= done_d;
      sim_q    <= sim_d;
      err_q    <= err_d;
    end
  end

  bram_pair_align #(
    .DATA_W   (DATA_W),
    .BRAM_LAT (BRAM_LAT)
  ) u_align (
    .clk        (clk),
    .rst        (rst),
    .issue      (en_q),
    .dout_a     (bram_a_dout),
    .dout_b     (bram_b_dout),
    .xt         (xt),
    .xt_1       (xt_1),
    .beat_valid (beat_valid),
    .pending    (align_pending)
  );

  assign bram_a_en   = en_q;
  assign bram_b_en   = en_q;
  assign bram_a_addr = addr_a_q;
  assign bram_b_addr = addr_b_q;
  assign count       = count_q;
  assign chk_idle    = idle_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign similar     = sim_q;
  assign err         = err_q;

endmodule

// File: doc/similarity_feed_ctrl.md
# similarity_feed_ctrl

Initiator-side controller for the frame similarity checker. On a start pulse it reads two frames beat by beat from two BRAM read ports (current frame A, previous frame B). It presents each aligned 1024-bit word pair with a valid strobe and a stable beat count, then waits for the checker's done/flag pair and returns the verdict to the system sequencer. It also owns the checker's idle (hold/abort) control.

## Interface
- DATA_W, 1024, width of one frame word
- ADDR_W, 8, BRAM word-address width
- BRAM_LAT, 2, BRAM read latency in cycles (en/addr to dout valid), legal 1..4
- TIMEOUT, 1023, max cycles spent waiting for checker done
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; accepted only in IDLE
- base_a, base_b  in  ADDR_W  first word address of frame A / frame B
- beats  in  8  words per frame
- bram_a_en, bram_b_en  out  1  read enables
- bram_a_addr, bram_b_addr  out  ADDR_W  read addresses
- bram_a_dout, bram_b_dout  in  DATA_W  read data
- xt, xt_1  out  DATA_W  aligned word pair (A, B) to checker
- beat_valid  out  1  xt/xt_1 hold a valid beat this cycle
- count  out  8  beat count to checker; latched beats, stable while busy
- chk_idle  out  1  hold/abort for checker; 1 = checker held in reset-like idle
- chk_done  in  1  checker finished (level)
- chk_flag  in  1  checker similarity verdict, valid when chk_done=1
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- similar  out  1  registered verdict, held until next done
- err  out  1  registered timeout indicator, held until next done

## Operation
- Reset values: bram_*_en=0, bram_*_addr=0, xt=xt_1=0, beat_valid=0, count=0, chk_idle=1, busy=0, done=0, similar=0, err=0, state IDLE.
- States: IDLE, ISSUE, DRAIN, WAIT_CHK, FINISH.
- IDLE:
  - start=1 and beats≠0: latch base_a, base_b, beats into count; busy=1; chk_idle=0; go to ISSUE.
  - start=1 and beats=0: go to FINISH with similar=0, err=0. No BRAM reads; chk_idle stays 1.
- ISSUE: one read per cycle on both ports, en=1, addr = base + i, for i = 0..beats-1. Addresses wrap modulo 2^ADDR_W. After the last issue, go to DRAIN.
- Alignment: a BRAM_LAT-deep valid shift register tracks issues. When its output is 1, capture bram_a_dout→xt and bram_b_dout→xt_1, and beat_valid=1 the following cycle. beat_valid pulses exactly beats times, contiguously.
- DRAIN: en=0; stay until the shift register is empty and the last beat has been presented; then go to WAIT_CHK.
- WAIT_CHK: a wait counter counts cycles.
  - chk_done=1: similar←chk_flag, err←0.
  - Counter reaches TIMEOUT with no chk_done: similar←0, err←1.
  - Either outcome goes to FINISH.
- FINISH: done=1 for one cycle, busy=0, chk_idle=1; return to IDLE.
- start while busy: ignored, with no effect on latched values.
- rst low in any state: all outputs take reset values next edge; in-flight BRAM data is discarded. chk_idle=1 aborts the checker.
- chk_done asserted outside WAIT_CHK: ignored.

## Timing
- Start seen at edge E: first en/addr at E+1 (first ISSUE cycle).
- First beat_valid at E+1+BRAM_LAT+1. Last at E+BRAM_LAT+1+beats.
- chk_idle falls at E+1, before the first beat, and stays 0 through WAIT_CHK.
- chk_done seen at edge D: similar/err update at D+1, coinciding with the done pulse.
- beats=0: done at E+1.
- Back-to-back: a start in the cycle after done is accepted.

## Structure
- Shared package/header similarity_pkg holds:
  - state encodings
  - DATA_W
  - similarity threshold constant 4080, shared with the checker
  - beat-count width (8)
- Sub-module bram_pair_align: BRAM_LAT valid delay line plus xt/xt_1 capture registers; parameters DATA_W and BRAM_LAT.
- Top: FSM, address counters, wait counter, result registers.

## Test plan
- beats=4, BRAM_LAT=2, base_a=0x10, base_b=0x20, memory word = address pattern.
  - Addresses 0x10–0x13 / 0x20–0x23 issued at E+1..E+4.
  - beat_valid high E+4..E+7, xt=memA[0x10+i], xt_1=memB[0x20+i], count=4 throughout.
- Same run, chk_done=1 with chk_flag=1 three cycles after the last beat.
  - done pulse next cycle, similar=1, err=0, chk_idle=1, busy=0.
- beats=0: done at E+1, no bram_en, similar=0, chk_idle never drops.
- base_a=0xFE, beats=4: addresses 0xFE, 0xFF, 0x00, 0x01. Repeat with BRAM_LAT=1 and 4 and confirm valid alignment.
- chk_done never asserted: done exactly TIMEOUT cycles after entering WAIT_CHK, err=1, similar=0. Next run clears err.
- rst low during ISSUE: next cycle all outputs at reset values. start during busy ignored. A fresh start afterwards completes normally.
